// File: rtl/norm_arbiter.sv
// norm_arbiter: shares one mantissa normalizer between the FP adder (requester 0)
// and FP multiplier (requester 1). Two-entry pipeline: S1 holds the granted
// operand, S2 is the registered normalized output.
// Optional build macro: NORM_ARB_FIXED_PRIO_EN. When it is defined, requester 0
// always wins a tie. When it is undefined (default), arbitration is round-robin.
module norm_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_valid,
   output logic        r0_ready,
   input  logic [7:0]  r0_exp,
   input  logic [24:0] r0_frac,
   input  logic        r1_valid,
   output logic        r1_ready,
   input  logic [7:0]  r1_exp,
   input  logic [24:0] r1_frac,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_id,
   output logic [7:0]  out_exp,
   output logic [23:0] out_frac,
   output logic        out_zero
);

   logic        s1_valid;
   logic        s1_id;
   logic [7:0]  s1_exp;
   logic [24:0] s1_frac;

   logic        s2_free, s1_free;
   logic        grant0, grant1;
   logic        r0_take, r1_take, accept;

   logic [4:0]  nlz;
   logic [8:0]  e_adj;
   logic [23:0] nfrac;
   logic        flush;

   assign s2_free = ~out_valid | out_ready;
   assign s1_free = ~s1_valid | s2_free;

`ifdef NORM_ARB_FIXED_PRIO_EN
   // Fixed priority: requester 0 wins every tie.
   always_comb begin
      grant0 = r0_valid;
      grant1 = r1_valid & ~r0_valid;
   end
`else
   logic last;

   // Round-robin: on a tie, grant the requester that was not accepted last.
   always_comb begin
      grant0 = r0_valid & (~r1_valid | last);
      grant1 = r1_valid & (~r0_valid | ~last);
   end

   // Remember who was accepted last. Reset to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!rst_n)
         last <= 1'b1;
      else if (accept)
         last <= r1_take;
   end
`endif

   // Ready is held low during reset, so nothing appears accepted while state is being cleared.
   assign r0_ready = rst_n & grant0 & s1_free;
   assign r1_ready = rst_n & grant1 & s1_free;
   assign r0_take  = r0_valid & r0_ready;
   assign r1_take  = r1_valid & r1_ready;
   assign accept   = r0_take | r1_take;

   // S1 input register: load on accept, otherwise empty it when S2 takes its contents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_id    <= 1'b0;
         s1_exp   <= '0;
         s1_frac  <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_id    <= r1_take;
         s1_exp   <= r1_take ? r1_exp  : r0_exp;
         s1_frac  <= r1_take ? r1_frac : r0_frac;
      end else if (s2_free) begin
         s1_valid <= 1'b0;
      end
   end

   // Leading-zero count over the 25-bit fraction. An all-zero fraction gives 25.
   // The highest set bit is visited last, so it determines the count.
   always_comb begin
      nlz = 5'd25;
      for (int i = 0; i < 25; i++)
         if (s1_frac[i]) nlz = 5'(24 - i);
   end

   // Shift the leading one into bit 24 and drop the guard bit. The exponent
   // adjust (+1 for the carry position, -n) needs only 9 bits: bit 8 is set for
   // any negative result and also for 256, and both cases flush.
   always_comb begin
      nfrac = 24'((s1_frac << nlz) >> 1);
      e_adj = {1'b0, s1_exp} + 9'd1 - {4'b0, nlz};
      flush = (s1_frac == 25'd0) | e_adj[8];
   end

   // S2 output register: load from S1 when there is room, otherwise clear
   // out_valid once the consumer has taken the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_id    <= 1'b0;
         out_exp   <= '0;
         out_frac  <= '0;
         out_zero  <= 1'b0;
      end else if (s1_valid && s2_free) begin
         out_valid <= 1'b1;
         out_id    <= s1_id;
         out_exp   <= flush ? 8'd0  : e_adj[7:0];
         out_frac  <= flush ? 24'd0 : nfrac;
         out_zero  <= flush;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_norm_arbiter.sv
// Self-checking bench for norm_arbiter: directed table vectors, multi-cycle
// corner sequences, and a randomized run scored against a behavioural model.
module tb_norm_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [7:0]  r0_exp, r1_exp;
   logic [24:0] r0_frac, r1_frac;
   logic        out_valid, out_ready, out_id, out_zero;
   logic [7:0]  out_exp;
   logic [23:0] out_frac;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   norm_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_exp(r0_exp), .r0_frac(r0_frac),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_exp(r1_exp), .r1_frac(r1_frac),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_exp(out_exp), .out_frac(out_frac), .out_zero(out_zero)
   );

   typedef struct {
      logic [7:0]  exp_in;
      logic [24:0] frac_in;
      logic [7:0]  exp_out;
      logic [23:0] frac_out;
      logic        zero_out;
   } vec_t;

   typedef struct {
      int id;
      int e;
      int f;
      int z;
   } res_t;

   res_t        sb[$];
   int          last_m;
   logic        stalled;
   logic [33:0] held;
   logic        acc0_q, acc1_q;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference normalization from the arithmetic rules: find the top set bit,
   // shift it to the carry position, and flush when the exponent leaves 0..255.
   function automatic res_t ref_norm(input int id, input int e, input int f);
      res_t r;
      int p, n, ee;
      r.id = id;
      if (f == 0) begin
         r.e = 0; r.f = 0; r.z = 1;
         return r;
      end
      p = 24;
      while (((f >> p) & 1) == 0) p--;
      n  = 24 - p;
      ee = e + 1 - n;
      if (ee < 0 || ee > 255) begin
         r.e = 0; r.f = 0; r.z = 1;
      end else begin
         r.e = ee;
         r.f = ((f << n) >> 1) & 32'hFFFFFF;
         r.z = 0;
      end
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; r0_valid = 0; r1_valid = 0; out_ready = 1'b1;
      r0_exp = 0; r0_frac = 0; r1_exp = 0; r1_frac = 0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Per-cycle model check for the random phase: readiness, grant, result order, hold.
   task automatic sample_cycle();
      res_t r;
      logic can, e0, e1;
      int w;
      @(negedge clk);
      can = (sb.size() < 2) || out_ready;
`ifdef NORM_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = 1 - last_m;
`endif
      e0 = can && r0_valid && (!r1_valid || w == 0);
      e1 = can && r1_valid && (!r0_valid || w == 1);
      chk("r0_ready", r0_ready, e0);
      chk("r1_ready", r1_ready, e1);
      if (stalled) chk("hold_stable", {out_id, out_zero, out_exp, out_frac}, held);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("spurious_out", 1, 0);
         else begin
            r = sb.pop_front();
            chk("rand_result", {out_id, out_zero, out_exp, out_frac},
                {r.id[0], r.z[0], r.e[7:0], r.f[23:0]});
         end
      end
      stalled = out_valid && !out_ready;
      held    = {out_id, out_zero, out_exp, out_frac};
      acc0_q  = r0_valid && r0_ready;
      acc1_q  = r1_valid && r1_ready;
      if (acc0_q) begin sb.push_back(ref_norm(0, int'(r0_exp), int'(r0_frac))); last_m = 0; end
      if (acc1_q) begin sb.push_back(ref_norm(1, int'(r1_exp), int'(r1_frac))); last_m = 1; end
      step();
   endtask

   initial begin
      vec_t vt[10];
      int   acc, id;
      logic [33:0] snap;
      logic [24:0] rf;

      vt[0] = '{8'h80, 25'h0800000, 8'h80, 24'h800000, 1'b0};
      vt[1] = '{8'h7F, 25'h1000000, 8'h80, 24'h800000, 1'b0};
      vt[2] = '{8'h55, 25'h0000000, 8'h00, 24'h000000, 1'b1};
      vt[3] = '{8'h02, 25'h0000100, 8'h00, 24'h000000, 1'b1};
      vt[4] = '{8'h10, 25'h0000001, 8'h00, 24'h000000, 1'b1};
      vt[5] = '{8'h20, 25'h0000001, 8'h09, 24'h800000, 1'b0};
      vt[6] = '{8'hFF, 25'h1000000, 8'h00, 24'h000000, 1'b1};
      vt[7] = '{8'h01, 25'h0C00000, 8'h01, 24'hC00000, 1'b0};
      vt[8] = '{8'h00, 25'h0400000, 8'h00, 24'h000000, 1'b1};
      vt[9] = '{8'h03, 25'h1FFFFFF, 8'h04, 24'hFFFFFF, 1'b0};

      // Reset state
      do_reset();
      rst_n = 1'b0;
      step();
      chk("reset_outs", {out_valid, out_id, out_zero, out_exp, out_frac, r0_ready, r1_ready}, 0);
      rst_n = 1'b1;

      // Table: single ops alternating requesters, two-edge latency
      for (int i = 0; i < 10; i++) begin
         id = i % 2;
         if (id == 0) begin r0_valid = 1; r0_exp = vt[i].exp_in; r0_frac = vt[i].frac_in; end
         else begin r1_valid = 1; r1_exp = vt[i].exp_in; r1_frac = vt[i].frac_in; end
         @(negedge clk);
         chk("tbl_ready", {r1_ready, r0_ready}, (id == 0) ? 2'b01 : 2'b10);
         step();
         r0_valid = 0; r1_valid = 0;
         chk("tbl_lat_k", out_valid, 0);
         step();
         chk("tbl_lat_k1", out_valid, 1);
         chk("tbl_result", {out_id, out_zero, out_exp, out_frac},
             {id[0], vt[i].zero_out, vt[i].exp_out, vt[i].frac_out});
         step();
      end

      // Contention: both valid, full rate
      do_reset();
      r0_valid = 1; r0_exp = 8'h80; r0_frac = 25'h0800000;
      r1_valid = 1; r1_exp = 8'h7F; r1_frac = 25'h1000000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
`ifdef NORM_ARB_FIXED_PRIO_EN
         chk("contention_grant", {r1_ready, r0_ready}, 2'b01);
`else
         chk("contention_grant", {r1_ready, r0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
         if (i >= 2) chk("contention_rate", out_valid, 1);
         step();
      end
      r0_valid = 0; r1_valid = 0;

      // Backpressure: two accepts, then stall with stable output, then ordered drain
      do_reset();
      out_ready = 0;
      r0_valid = 1; r0_exp = 8'h80; r0_frac = 25'h0800000;
      r1_valid = 1; r1_exp = 8'h20; r1_frac = 25'h0000001;
      acc = 0;
      snap = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if ((r0_valid && r0_ready) || (r1_valid && r1_ready)) acc++;
         if (i == 2) snap = {out_id, out_zero, out_exp, out_frac};
         if (i >= 2) begin
            chk("bp_ready_low", {r1_ready, r0_ready}, 2'b00);
            chk("bp_hold", {out_valid, out_id, out_zero, out_exp, out_frac}, {1'b1, snap});
         end
         step();
      end
      chk("bp_accepts", acc, 2);
      r0_valid = 0; r1_valid = 0; out_ready = 1;
      @(negedge clk);
      chk("bp_drain0", {out_valid, out_id, out_zero, out_exp, out_frac}, {2'b10, 1'b0, 8'h80, 24'h800000});
      step();
      @(negedge clk);
`ifdef NORM_ARB_FIXED_PRIO_EN
      chk("bp_drain1", {out_valid, out_id, out_zero, out_exp, out_frac}, {2'b10, 1'b0, 8'h80, 24'h800000});
`else
      chk("bp_drain1", {out_valid, out_id, out_zero, out_exp, out_frac}, {2'b11, 1'b0, 8'h09, 24'h800000});
`endif
      step();
      @(negedge clk);
      chk("bp_empty", out_valid, 0);
      step();

      // Reset mid-stream: fill both stages with last accept = 0, then reset
      do_reset();
      out_ready = 0;
      r1_valid = 1; r1_exp = 8'h80; r1_frac = 25'h0800000;
      step();
      r1_valid = 0;
      r0_valid = 1; r0_exp = 8'h80; r0_frac = 25'h0800000;
      step();
      chk("mid_full", out_valid, 1);
      r1_valid = 1;
      rst_n = 0;
      step();
      rst_n = 1;
      chk("mid_rst_out", out_valid, 0);
      @(negedge clk);
      chk("mid_rst_tie", {r1_ready, r0_ready}, 2'b01);
      step();
      r0_valid = 0; r1_valid = 0;

      // Randomized run against the behavioural model
      do_reset();
      sb.delete();
      last_m = 1; stalled = 0; held = '0; acc0_q = 0; acc1_q = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!r0_valid || acc0_q) begin
            r0_valid = ($urandom % 3) != 0;
            rf = 25'($urandom) >> ($urandom % 26);
            r0_exp = 8'($urandom); r0_frac = rf;
         end
         if (!r1_valid || acc1_q) begin
            r1_valid = ($urandom % 3) != 0;
            rf = 25'($urandom) >> ($urandom % 26);
            r1_exp = 8'($urandom); r1_frac = rf;
         end
         out_ready = ($urandom % 4) != 0;
         sample_cycle();
      end
      r0_valid = 0; r1_valid = 0; out_ready = 1;
      for (int c = 0; c < 6; c++) sample_cycle();
      chk("rand_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
